bcd_result_conv: RTL

- Sequential signed-binary-to-BCD converter sitting directly downstream of the Booth multiplier.
- Captures the 16-bit signed product on the multiplier's one-cycle `valid` pulse.
- Converts the magnitude to 4 BCD digits using iterative shift-add-3 (double dabble), one bit per clock.
- Presents digits, sign and overflow to the display stage. A one-entry pending buffer absorbs a product that arrives while a conversion is running.

---
 rtl/bcd_result_conv_pkg.sv | 22 ++
 rtl/bcd_add3.sv | 21 ++
 rtl/bcd_result_conv.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_result_conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_result_conv_pkg
// Description : Shared types and constants for the signed-binary-to-BCD
//               result converter: FSM state encoding, BCD digit width and
//               the double-dabble adjust constants.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_result_conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int         c_BCD_W      = 4;
  localparam logic [3:0] c_ADJ_THRESH = 4'd5;
  localparam logic [3:0] c_ADJ_ADD    = 4'd3;

endpackage
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
// Module      : bcd_add3
// Description : Double-dabble digit correction. Adds 3 to a BCD digit that is
//               5 or more so the following left shift carries into the next
//               decimal digit.
// Ports       : digit - BCD digit before correction
//               adj   - corrected digit
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3
  import bcd_result_conv_pkg::*;
(
  input  logic [c_BCD_W-1:0] digit,
  output logic [c_BCD_W-1:0] adj
);

  assign adj = (digit >= c_ADJ_THRESH) ? (digit + c_ADJ_ADD) : digit;

endmodule
`default_nettype wire

// File: rtl/bcd_result_conv.sv
`default_nettype none
// ============================================================================
// Module      : bcd_result_conv
// Description : Sequential signed-binary-to-BCD converter. Captures a signed
//               product on start, converts its magnitude with one double-dabble
//               iteration per clock and publishes digits, sign and overflow.
//               A one-entry pending buffer holds a product that arrives while
//               a conversion is running.
// Ports       : clk   - rising-edge clock
//               rst   - asynchronous reset, active-low
//               start - one-cycle strobe, bin sampled when high
//               bin   - signed two's-complement input
//               bcd   - BCD digits, [3:0] is the units digit
//               neg   - result negative (never for zero)
//               ovf   - magnitude exceeds MAX_VAL (bcd then reads all 9s)
//               busy  - converter in SHIFT or DONE
//               done  - one-cycle pulse when bcd/neg/ovf update
//               lost  - one-cycle pulse when the pending value is overwritten
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_result_conv
  import bcd_result_conv_pkg::*;
#(
  parameter int IN_W    = 16,
  parameter int DIGITS  = 4,
  parameter int MAX_VAL = 9999
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [IN_W-1:0]           bin,
  output logic [c_BCD_W*DIGITS-1:0] bcd,
  output logic                      neg,
  output logic                      ovf,
  output logic                      busy,
  output logic                      done,
  output logic                      lost
);

  localparam int                BCD_TOT = c_BCD_W * DIGITS;
  localparam int                SCR_W   = BCD_TOT + IN_W;
  localparam int                CNT_W   = $clog2(IN_W);
  localparam logic [CNT_W-1:0]  c_LAST  = CNT_W'(IN_W - 1);
  localparam logic [IN_W-1:0]   c_MAX   = IN_W'(MAX_VAL);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SCR_W-1:0]     r_scr;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_neg_n;
  logic                 r_ovf_n;
  logic [IN_W-1:0]      r_pend;
  logic                 r_pend_vld;
  logic [BCD_TOT-1:0]   r_bcd;
  logic                 r_neg;
  logic                 r_ovf;
  logic                 r_done;
  logic                 r_lost;

  logic                 w_load;
  logic                 w_use_pend;
  logic                 w_pend_wr;
  logic                 w_pend_clr;
  logic                 w_lost;
  logic                 w_finish;
  logic [IN_W-1:0]      w_src;
  logic [IN_W-1:0]      w_mag;
  logic [SCR_W-1:0]     w_adj;

  // Digit correction on the BCD field; the binary field passes unchanged.
  assign w_adj[IN_W-1:0] = r_scr[IN_W-1:0];

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      bcd_add3 u_add3 (
        .digit (r_scr[IN_W + c_BCD_W*g +: c_BCD_W]),
        .adj   (w_adj[IN_W + c_BCD_W*g +: c_BCD_W])
      );
    end
  endgenerate

  // Magnitude in IN_W bits as unsigned: the most negative input maps to
  // 2^(IN_W-1) and is caught by the overflow compare.
  assign w_src = w_use_pend ? r_pend : bin;
  assign w_mag = w_src[IN_W-1] ? (IN_W'(0) - w_src) : w_src;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_use_pend  = 1'b0;
    w_pend_wr   = 1'b0;
    w_pend_clr  = 1'b0;
    w_lost      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == c_LAST) w_state_nxt = ST_DONE;
        if (start) begin
          w_pend_wr = 1'b1;
          w_lost    = r_pend_vld;
        end
      end
      ST_DONE: begin
        w_finish = 1'b1;
        if (r_pend_vld) begin
          // Engine drains the buffer; a coincident start refills it.
          w_load      = 1'b1;
          w_use_pend  = 1'b1;
          w_pend_wr   = start;
          w_pend_clr  = !start;
          w_state_nxt = ST_SHIFT;
        end else if (start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scr      <= '0;
      r_cnt      <= '0;
      r_neg_n    <= 1'b0;
      r_ovf_n    <= 1'b0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_bcd      <= '0;
      r_neg      <= 1'b0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
      r_lost     <= 1'b0;
    end else begin
      r_done <= w_finish;
      r_lost <= w_lost;

      if (w_load) begin
        r_scr   <= {{BCD_TOT{1'b0}}, w_mag};
        r_cnt   <= '0;
        r_neg_n <= w_src[IN_W-1];
        r_ovf_n <= (w_mag > c_MAX);
      end else if (r_state == ST_SHIFT) begin
        r_scr <= {w_adj[SCR_W-2:0], 1'b0};
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_pend_wr) begin
        r_pend     <= bin;
        r_pend_vld <= 1'b1;
      end else if (w_pend_clr) begin
        r_pend_vld <= 1'b0;
      end

      if (w_finish) begin
        r_bcd <= r_ovf_n ? {DIGITS{4'h9}} : r_scr[IN_W +: BCD_TOT];
        r_neg <= r_neg_n;
        r_ovf <= r_ovf_n;
      end
    end
  end

  assign bcd  = r_bcd;
  assign neg  = r_neg;
  assign ovf  = r_ovf;
  assign done = r_done;
  assign lost = r_lost;
  assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire
